inst_fetch: RTL and testbench

// Instruction-fetch stage of the MIPS core; sits directly upstream of the instruction memory.

---
 rtl/inst_fetch.sv | 109 ++++++++++
 tb/tb_inst_fetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: owns the PC, drives the instruction memory,
// and registers the fetched word into IF/ID with stall, delay-slot redirect and flush handling.
module inst_fetch #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] new_pc_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              imem_ce,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic [ADDR_W-1:0] id_pc,
   output logic [31:0]       id_inst,
   output logic              id_valid,
   output logic              id_exc_adel
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       inst;
      logic              valid;
      logic              adel;
   } ifid_t;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ce_q, ce_d;
   logic              pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   ifid_t             ifid_q, ifid_d;
   logic              misaligned;

   assign misaligned = (pc_q[1:0] != 2'b00);

   // PC / pending-redirect next state; flush wins even before the memory is enabled
   always_comb begin
      pc_d       = pc_q;
      ce_d       = 1'b1;
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
      if (flush_i) begin
         pc_d       = new_pc_i;
         pend_vld_d = 1'b0;
      end else if (ce_q) begin
         if (stall_i) begin
            if (branch_flag_i) begin
               pend_tgt_d = branch_target_i;
               pend_vld_d = 1'b1;
            end
         end else if (pend_vld_q) begin
            pc_d       = pend_tgt_q;
            pend_vld_d = 1'b0;
         end else if (branch_flag_i) begin
            pc_d = branch_target_i;
         end else begin
            pc_d = pc_q + ADDR_W'(4);
         end
      end
   end

   // IF/ID: the word fetched this cycle always enters, so a redirect leaves it as the delay slot
   always_comb begin
      ifid_d = ifid_q;
      if (flush_i) begin
         ifid_d.pc    = pc_q;
         ifid_d.inst  = '0;
         ifid_d.valid = 1'b0;
         ifid_d.adel  = 1'b0;
      end else if (!stall_i) begin
         if (!ce_q) begin
            ifid_d.valid = 1'b0;
            ifid_d.inst  = '0;
         end else begin
            ifid_d.pc    = pc_q;
            ifid_d.valid = 1'b1;
            ifid_d.adel  = misaligned;
            ifid_d.inst  = misaligned ? 32'h0 : imem_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         ce_q       <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
         ifid_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         ce_q       <= ce_d;
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
         ifid_q     <= ifid_d;
      end
   end

   assign imem_ce     = ce_q;
   assign imem_addr   = pc_q;
   assign id_pc       = ifid_q.pc;
   assign id_inst     = ifid_q.inst;
   assign id_valid    = ifid_q.valid;
   assign id_exc_adel = ifid_q.adel;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for the main fetch/stall/branch/flush flow,
// plus hand-written sequences for async reset and flush before the memory is enabled.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i, branch_flag_i;
   logic [31:0] new_pc_i, branch_target_i;
   logic        imem_ce;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] id_pc, id_inst;
   logic        id_valid, id_exc_adel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign imem_data = imem_ce ? memw(imem_addr) : 32'h0;

   inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .imem_ce(imem_ce), .imem_addr(imem_addr), .imem_data(imem_data),
      .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_exc_adel(id_exc_adel)
   );

   typedef struct {
      logic        stall, flush, bflag;
      logic [31:0] npc, btgt;
      logic        e_ce;
      logic [31:0] e_addr, e_pc;
      logic        e_valid, e_adel;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic st, input logic fl, input logic [31:0] npc,
                      input logic bf, input logic [31:0] bt, input logic ce,
                      input logic [31:0] addr, input logic [31:0] pc,
                      input logic vld, input logic adel);
      vec_t v;
      v.stall = st; v.flush = fl; v.npc = npc; v.bflag = bf; v.btgt = bt;
      v.e_ce = ce; v.e_addr = addr; v.e_pc = pc; v.e_valid = vld; v.e_adel = adel;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic fl, input logic [31:0] npc,
                        input logic bf, input logic [31:0] bt);
      stall_i = st; flush_i = fl; new_pc_i = npc; branch_flag_i = bf; branch_target_i = bt;
   endtask

   task automatic chk_all(input string tag, input logic ce, input logic [31:0] addr,
                          input logic [31:0] pc, input logic vld, input logic adel);
      logic [31:0] e_inst;
      e_inst = (vld && !adel) ? memw(pc) : 32'h0;
      chk({tag, " imem_ce"},     32'(imem_ce),     32'(ce));
      chk({tag, " imem_addr"},   imem_addr,        addr);
      chk({tag, " id_pc"},       id_pc,            pc);
      chk({tag, " id_inst"},     id_inst,          e_inst);
      chk({tag, " id_valid"},    32'(id_valid),    32'(vld));
      chk({tag, " id_exc_adel"}, 32'(id_exc_adel), 32'(adel));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      #3;
      chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      //  st fl npc           bf bt            ce addr          id_pc         vld adel
      add(0, 0, 0,            0, 0,            1, 32'h0,        32'h0,        0, 0);
      add(0, 0, 0,            0, 0,            1, 32'h4,        32'h0,        1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h8,        32'h4,        1, 0);
      add(0, 0, 0,            0, 0,            1, 32'hC,        32'h8,        1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h10,       32'hC,        1, 0);
      add(1, 0, 0,            0, 0,            1, 32'h10,       32'hC,        1, 0);
      add(1, 0, 0,            0, 0,            1, 32'h10,       32'hC,        1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h14,       32'h10,       1, 0);
      add(0, 0, 0,            1, 32'h100,      1, 32'h100,      32'h14,       1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h104,      32'h100,      1, 0);
      add(1, 0, 0,            1, 32'h200,      1, 32'h104,      32'h100,      1, 0);
      add(1, 0, 0,            0, 0,            1, 32'h104,      32'h100,      1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h200,      32'h104,      1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h204,      32'h200,      1, 0);
      add(1, 0, 0,            1, 32'h300,      1, 32'h204,      32'h200,      1, 0);
      add(1, 1, 32'h20,       0, 0,            1, 32'h20,       32'h204,      0, 0);
      add(0, 0, 0,            0, 0,            1, 32'h24,       32'h20,       1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h28,       32'h24,       1, 0);
      add(0, 0, 0,            1, 32'h102,      1, 32'h102,      32'h28,       1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h106,      32'h102,      1, 1);
      add(0, 0, 0,            0, 0,            1, 32'h10A,      32'h106,      1, 1);
      add(0, 1, 32'h20,       0, 0,            1, 32'h20,       32'h10A,      0, 0);
      add(0, 0, 0,            0, 0,            1, 32'h24,       32'h20,       1, 0);
      add(0, 1, 32'hFFFFFFFC, 0, 0,            1, 32'hFFFFFFFC, 32'h24,       0, 0);
      add(0, 0, 0,            0, 0,            1, 32'h0,        32'hFFFFFFFC, 1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h4,        32'h0,        1, 0);
      add(1, 0, 0,            1, 32'h40,       1, 32'h4,        32'h0,        1, 0);
      add(1, 0, 0,            1, 32'h80,       1, 32'h4,        32'h0,        1, 0);
      add(0, 0, 0,            0, 0,            1, 32'h80,       32'h4,        1, 0);

      #9 rst = 1'b0;
      foreach (tbl[i]) begin
         drive(tbl[i].stall, tbl[i].flush, tbl[i].npc, tbl[i].bflag, tbl[i].btgt);
         @(posedge clk); #1;
         chk_all($sformatf("row%0d", i), tbl[i].e_ce, tbl[i].e_addr, tbl[i].e_pc,
                 tbl[i].e_valid, tbl[i].e_adel);
      end

      // leave a redirect pending, then reset asynchronously mid-cycle
      drive(1, 0, 0, 1, 32'h300);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk_all("post_rst0", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk_all("post_rst1", 1'b1, 32'h4, 32'h0, 1'b1, 1'b0);

      // flush on the very first edge, before the memory is enabled
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      drive(0, 1, 32'h50, 0, 0);
      @(posedge clk); #1;
      chk_all("flush_ce0", 1'b1, 32'h50, 32'h0, 1'b0, 1'b0);
      drive(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk_all("flush_ce0_next", 1'b1, 32'h54, 32'h50, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
